// File: rtl/lab61soc_input_pio.sv
// Avalon-MM input PIO: synchronised, debounced inputs with sticky edge capture and a maskable level irq.
// Latency: DATA on readdata SYNC_STAGES+max(N,1)+1 clocks after an input change; register reads are one clock.
// Backpressure: none; the slave never stalls, readdata is reloaded from the addressed register every clock.
module lab61soc_input_pio #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_w;
  logic [WIDTH-1:0] db_q, db_d;
  logic [WIDTH-1:0] db_prev_q;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] ec_q, ec_d;
  logic [WIDTH-1:0] edge_sel;
  logic [31:0]      rd_q, rd_d;
  logic             wr_mask, wr_ec;
  logic             unused_wdata;

  // Upper write-data bits beyond WIDTH have no register behind them.
  assign unused_wdata = ^writedata;

  // Synchroniser chain: in_port enters stage 0, the last stage feeds the debouncer.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_w = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
      // Debounce bypassed: the debounced level simply follows the synchroniser.
      always_comb begin
        db_d = sync_w;
      end
    end else begin : g_debounce
      localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
      localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] cnt_q [WIDTH];
      logic [CW-1:0] cnt_d [WIDTH];

      // Per-bit run counter: any sample agreeing with db restarts it; N disagreeing samples flip db.
      always_comb begin
        db_d = db_q;
        for (int i = 0; i < WIDTH; i++) begin
          cnt_d[i] = '0;
          if (sync_w[i] != db_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
              db_d[i] = sync_w[i];
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
        end
      end

      // Counter state; reset discards any qualification in progress.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

  assign wr_mask = chipselect & write & (address == 2'd2);
  assign wr_ec   = chipselect & write & (address == 2'd3);

  // Edge selection, then sticky capture where a new edge beats a same-cycle clear.
  always_comb begin
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] clr;
    rise = db_q & ~db_prev_q;
    fall = ~db_q & db_prev_q;
    if (EDGE_TYPE == 0) begin
      edge_sel = rise;
    end else if (EDGE_TYPE == 1) begin
      edge_sel = fall;
    end else begin
      edge_sel = rise | fall;
    end
    clr    = wr_ec ? writedata[WIDTH-1:0] : '0;
    ec_d   = (ec_q & ~clr) | edge_sel;
    mask_d = wr_mask ? writedata[WIDTH-1:0] : mask_q;
  end

  // Read mux, zero-extended to the 32-bit bus; address 1 is reserved and reads zero.
  always_comb begin
    rd_d = '0;
    case (address)
      2'd0:    rd_d[WIDTH-1:0] = db_q;
      2'd2:    rd_d[WIDTH-1:0] = mask_q;
      2'd3:    rd_d[WIDTH-1:0] = ec_q;
      default: rd_d = '0;
    endcase
  end

  // Architectural registers and the registered read port.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_q      <= '0;
      db_prev_q <= '0;
      mask_q    <= '0;
      ec_q      <= '0;
      rd_q      <= '0;
    end else begin
      db_q      <= db_d;
      db_prev_q <= db_q;
      mask_q    <= mask_d;
      ec_q      <= ec_d;
      rd_q      <= rd_d;
    end
  end

  assign readdata = rd_q;
  assign irq      = |(ec_q & mask_q);

endmodule
